// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters
// (port 0: EXU integer ops, port 1: branch/jump unit). One transaction is held
// at a time. A drain and a new grant in the same cycle sustain one result per cycle.
module alu_arbiter #(
  parameter int                DATA_W  = 32,
  parameter int                ALUC_W  = 4,
  parameter logic [ALUC_W-1:0] IDLE_OP = {ALUC_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  // request channel
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [ALUC_W-1:0] req_aluc0,
  input  logic [ALUC_W-1:0] req_aluc1,
  input  logic [DATA_W-1:0] req_num1_0,
  input  logic [DATA_W-1:0] req_num1_1,
  input  logic [DATA_W-1:0] req_num2_0,
  input  logic [DATA_W-1:0] req_num2_1,
  // response channel
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  // shared ALU
  output logic [ALUC_W-1:0] alu_aluc,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  input  logic [DATA_W-1:0] alu_result
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_prio;
  logic               r_rsp_id;
  logic [DATA_W-1:0]  r_rsp_result;

  logic               w_can_grant;
  logic               w_grant;
  logic               w_winner;

  // Arbitration: a slot is free when idle or when the held result drains now.
  // Reset holds the grant low so the ALU and requesters see a quiet interface.
  always_comb begin
    w_can_grant = 1'b0;
    w_grant     = 1'b0;
    w_winner    = 1'b0;
    if (!rst_n) begin
      w_can_grant = 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        w_can_grant = 1'b1;
      end else begin
        w_can_grant = rsp_ready[r_rsp_id];
      end
      case (req_valid)
        2'b01:   w_winner = 1'b0;
        2'b10:   w_winner = 1'b1;
        2'b11:   w_winner = r_prio;
        default: w_winner = 1'b0;
      endcase
      w_grant = w_can_grant & (|req_valid);
    end
  end

  // Request acceptance and ALU input mux; idle opcode keeps the ALU on a legal code.
  always_comb begin
    req_ready = 2'b00;
    alu_aluc  = IDLE_OP;
    alu_num1  = {DATA_W{1'b0}};
    alu_num2  = {DATA_W{1'b0}};
    if (w_grant) begin
      if (w_winner) begin
        req_ready = 2'b10;
        alu_aluc  = req_aluc1;
        alu_num1  = req_num1_1;
        alu_num2  = req_num2_1;
      end else begin
        req_ready = 2'b01;
        alu_aluc  = req_aluc0;
        alu_num1  = req_num1_0;
        alu_num2  = req_num2_0;
      end
    end else begin
      req_ready = 2'b00;
    end
  end

  // Next-state logic: a grant always lands in RESP; a drain without grant returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        if (w_grant) begin
          w_state_nxt = S_RESP;
        end else if (rsp_ready[r_rsp_id]) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result capture, owner tag and round-robin pointer update on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= {DATA_W{1'b0}};
      r_rsp_id     <= 1'b0;
      r_prio       <= 1'b0;
    end else if (w_grant) begin
      r_rsp_result <= alu_result;
      r_rsp_id     <= w_winner;
      r_prio       <= ~w_winner;
    end else begin
      r_rsp_result <= r_rsp_result;
      r_rsp_id     <= r_rsp_id;
      r_prio       <= r_prio;
    end
  end

  // Response outputs are decoded purely from registered state.
  always_comb begin
    rsp_valid  = 2'b00;
    rsp_result = r_rsp_result;
    if (r_state == S_RESP) begin
      if (r_rsp_id) begin
        rsp_valid = 2'b10;
      end else begin
        rsp_valid = 2'b01;
      end
    end else begin
      rsp_valid = 2'b00;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a random soak,
// checked against a transaction-level model (one-slot response queue, last-winner fairness).
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam logic [AW-1:0] IDLE_OP = 4'd0;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [AW-1:0] alu_aluc;
  logic [DW-1:0] alu_num1;
  logic [DW-1:0] alu_num2;
  logic [DW-1:0] alu_result;

  logic [AW-1:0] p_aluc [2];
  logic [DW-1:0] p_n1   [2];
  logic [DW-1:0] p_n2   [2];

  int n_checks;
  int n_errors;
  int abort_cnt;

  alu_arbiter #(.DATA_W(DW), .ALUC_W(AW), .IDLE_OP(IDLE_OP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_aluc0  (p_aluc[0]),
    .req_aluc1  (p_aluc[1]),
    .req_num1_0 (p_n1[0]),
    .req_num1_1 (p_n1[1]),
    .req_num2_0 (p_n2[0]),
    .req_num2_1 (p_n2[1]),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .alu_aluc   (alu_aluc),
    .alu_num1   (alu_num1),
    .alu_num2   (alu_num2),
    .alu_result (alu_result)
  );

  // ALU behaviour: codes 0..7 legal, anything else is the abort path.
  function automatic logic [DW-1:0] ref_alu(input logic [AW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return {31'd0, ($signed(a) < $signed(b))};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_aluc, alu_num1, alu_num2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count any cycle where the ALU is driven with an illegal code.
  always @(posedge clk) begin
    if (rst_n && (alu_aluc > 4'd7)) abort_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction model: at most one held response; fairness via last winner.
  bit            m_held;
  bit            m_port;
  logic [DW-1:0] m_val;
  bit            m_last;
  int            m_wait [2];

  task automatic model_reset();
    m_held    = 1'b0;
    m_port    = 1'b0;
    m_val     = '0;
    m_last    = 1'b1;   // port 0 preferred after reset
    m_wait[0] = 0;
    m_wait[1] = 0;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input logic [1:0] v, input logic [1:0] rr, output bit granted, output bit win);
    bit can;
    req_valid = v;
    rsp_ready = rr;
    #1;
    can     = !m_held || rr[m_port];
    win     = (v == 2'b11) ? ~m_last : v[1];
    granted = can && (v != 2'b00);
    check_eq("req_ready", {30'd0, req_ready}, granted ? (32'd1 << win) : 32'd0);
    check_eq("alu_aluc", {28'd0, alu_aluc}, granted ? {28'd0, p_aluc[win]} : {28'd0, IDLE_OP});
    check_eq("alu_num1", alu_num1, granted ? p_n1[win] : 32'd0);
    check_eq("alu_num2", alu_num2, granted ? p_n2[win] : 32'd0);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (v[i] && !(granted && win == i)) begin
        if (granted) m_wait[i]++;
      end
    end
    if (granted) begin
      check_eq("fairness", (m_wait[win] <= 1) ? 32'd1 : 32'd0, 32'd1);
      m_wait[win] = 0;
    end
    if (m_held && rr[m_port]) m_held = 1'b0;
    if (granted) begin
      m_held = 1'b1;
      m_port = win;
      m_val  = ref_alu(p_aluc[win], p_n1[win], p_n2[win]);
      m_last = win;
    end
    @(negedge clk);
    check_eq("rsp_valid", {30'd0, rsp_valid}, m_held ? (32'd1 << m_port) : 32'd0);
    if (m_held) check_eq("rsp_result", rsp_result, m_val);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    p_aluc[p] = op;
    p_n1[p]   = a;
    p_n2[p]   = b;
  endtask

  bit            g;
  bit            w;
  logic [DW-1:0] held;
  bit            pend [2];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    abort_cnt = 0;
    set_req(0, 4'd0, 32'd0, 32'd0);
    set_req(1, 4'd0, 32'd0, 32'd0);

    // Reset state, with requests present to show they are gated.
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_req(0, 4'd3, 32'h1234, 32'h5678);
    set_req(1, 4'd4, 32'h9, 32'h3);
    model_reset();
    @(negedge clk);
    #1;
    check_eq("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check_eq("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_result", rsp_result, 32'd0);
    check_eq("rst_alu_aluc", {28'd0, alu_aluc}, 32'd0);
    check_eq("rst_alu_num1", alu_num1, 32'd0);
    check_eq("rst_alu_num2", alu_num2, 32'd0);
    do_reset();

    // Single request: ADD 5,7 on port 0.
    set_req(0, 4'd0, 32'd5, 32'd7);
    cycle(2'b01, 2'b00, g, w);
    check_eq("single_result", rsp_result, 32'd12);
    check_eq("single_valid", {30'd0, rsp_valid}, 32'd1);
    cycle(2'b00, 2'b01, g, w);
    check_eq("single_drained", {30'd0, rsp_valid}, 32'd0);

    // Contention from a fresh pointer: grants alternate starting with port 0.
    do_reset();
    set_req(0, 4'd1, 32'd10, 32'd3);
    set_req(1, 4'd4, 32'hF0, 32'hFF);
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, 2'b11, g, w);
      check_eq("cont_winner", {31'd0, w}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check_eq("cont_result", rsp_result, (i % 2 == 0) ? 32'd7 : 32'h0F);
    end

    // Backpressure: port 1 result held while port 0 waits.
    do_reset();
    set_req(1, 4'd2, 32'hFF00, 32'h0FF0);
    cycle(2'b10, 2'b00, g, w);
    held = rsp_result;
    set_req(0, 4'd0, 32'd100, 32'd23);
    for (int i = 0; i < 4; i++) begin
      cycle(2'b01, 2'b00, g, w);
      check_eq("bp_no_grant", {31'd0, g}, 32'd0);
      check_eq("bp_result_stable", rsp_result, held);
    end
    cycle(2'b01, 2'b10, g, w);
    check_eq("bp_release_grant", {31'd0, g}, 32'd1);
    check_eq("bp_release_result", rsp_result, 32'd123);
    cycle(2'b00, 2'b01, g, w);

    // Idle drive: no requests for 100 cycles with random response readiness.
    for (int i = 0; i < 100; i++) begin
      cycle(2'b00, 2'($urandom_range(0, 3)), g, w);
    end

    // Async reset while holding a result.
    set_req(0, 4'd0, 32'd1, 32'd2);
    cycle(2'b01, 2'b00, g, w);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_eq("async_req_ready", {30'd0, req_ready}, 32'd0);
    model_reset();
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 4'd3, 32'hA0, 32'h0B);
    set_req(1, 4'd1, 32'd50, 32'd8);
    cycle(2'b11, 2'b11, g, w);
    check_eq("async_first_winner", {31'd0, w}, 32'd0);
    check_eq("async_first_result", rsp_result, 32'hAB);
    cycle(2'b00, 2'b11, g, w);

    // Random soak: requesters hold valid and payload until accepted.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
          set_req(p, 4'($urandom_range(0, 7)), $urandom, $urandom);
          pend[p] = 1'b1;
        end
      end
      cycle({pend[1], pend[0]}, 2'($urandom_range(0, 3)), g, w);
      if (g) pend[w] = 1'b0;
    end

    check_eq("alu_abort_never", abort_cnt, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
